ada_exu_muldiv: RTL and testbench

//   Iterative multiply/divide unit in the EX stage; owns HI/LO registers.

---
 rtl/ada_exu_muldiv.sv | 166 ++++++++++++++++
 tb/tb_ada_exu_muldiv.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ada_exu_muldiv.sv
// Iterative multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one sign/zero fix-up cycle; owns the HI/LO registers.
module ada_exu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_mult,
  input  logic             op_multu,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mthi,
  input  logic             op_mtlo,
  input  logic             op_mfhi,
  input  logic             op_mflo,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             pipe_hold,
  input  logic             flush,
  output logic             exu_stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic             any_op, start_ok, sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_trial;
  logic             rem_ge;

  assign any_op    = op_mult | op_multu | op_div | op_divu |
                     op_mthi | op_mtlo  | op_mfhi | op_mflo;
  assign busy      = (state_q != S_IDLE);
  assign exu_stall = busy & any_op;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    raw_a_d   = raw_a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    start_ok = !pipe_hold && !flush;
    sgn      = op_mult | op_div;
    sa       = sgn & op_a[WIDTH-1];
    sb       = sgn & op_b[WIDTH-1];
    mag_a    = sa ? (~op_a + 1'b1) : op_a;
    mag_b    = sb ? (~op_b + 1'b1) : op_b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_trial = rem_sh - {1'b0, opd_q};
    rem_ge    = (rem_sh >= {1'b0, opd_q});

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (op_mult | op_multu | op_div | op_divu) begin
            state_d   = (op_div | op_divu) ? S_DIV : S_MUL;
            is_div_d  = op_div | op_divu;
            cnt_d     = CW'(WIDTH - 1);
            neg_quo_d = sa ^ sb;
            neg_rem_d = sa;
            raw_a_d   = op_a;
            dz_d      = (op_b == '0);
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend into the remainder.
            opd_d     = (op_div | op_divu) ? mag_b : mag_a;
            acc_d     = {{WIDTH{1'b0}}, ((op_div | op_divu) ? mag_a : mag_b)};
          end
          if (op_mthi) hi_d = op_a;
          if (op_mtlo) lo_d = op_a;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {(rem_ge ? rem_trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
        end else if (dz_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = raw_a_q;
        end else begin
          lo_d = neg_quo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                           : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts from any state and suppresses the FIX write-back.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      raw_a_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      raw_a_q   <= raw_a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_ada_exu_muldiv.sv
// Directed self-checking bench for ada_exu_muldiv: hand-computed results,
// busy/stall cycle counts, flush, held MTHI and asynchronous reset.
module tb_ada_exu_muldiv;

  localparam int W = 32;
  localparam logic [3:0] K_MULT = 4'b1000, K_MULTU = 4'b0100,
                         K_DIV  = 4'b0010, K_DIVU  = 4'b0001;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         op_mult = 0, op_multu = 0, op_div = 0, op_divu = 0;
  logic         op_mthi = 0, op_mtlo = 0, op_mfhi = 0, op_mflo = 0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         pipe_hold = 0, flush = 0;
  logic         exu_stall, busy;
  logic [W-1:0] hi, lo;

  int checks = 0, failures = 0;

  ada_exu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo), .op_mfhi(op_mfhi), .op_mflo(op_mflo),
    .op_a(op_a), .op_b(op_b), .pipe_hold(pipe_hold), .flush(flush),
    .exu_stall(exu_stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one mul/div op at the next edge, optionally follow it with an MFLO
  // that waits in EX, and count busy and stall cycles until the unit frees.
  task automatic run(input logic [3:0] ops, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic mflo, output int cycles, output int stalls);
    {op_mult, op_multu, op_div, op_divu} = ops;
    op_a = a;
    op_b = b;
    @(posedge clk);
    @(negedge clk);
    {op_mult, op_multu, op_div, op_divu} = 4'b0000;
    op_mflo = mflo;
    cycles = 0;
    stalls = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (exu_stall) stalls++;
      @(negedge clk);
    end
  endtask

  int cyc, stl;

  initial begin
    #3;
    check("rst_busy", busy, 0);
    check("rst_stall", exu_stall, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(K_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, cyc, stl);
    check("multu_busy_cycles", cyc, 33);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run(K_MULT, -32'sd3, 32'd7, 1'b1, cyc, stl);
    check("mult_busy_cycles", cyc, 33);
    check("mult_mflo_stall_cycles", stl, 33);
    check("mult_stall_drops", exu_stall, 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    op_mflo = 1'b0;

    run(K_DIV, -32'sd7, 32'd2, 1'b0, cyc, stl);
    check("div_busy_cycles", cyc, 33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run(K_DIVU, 32'd100, 32'd7, 1'b0, cyc, stl);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run(K_DIVU, 32'd7, 32'd0, 1'b0, cyc, stl);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);

    run(K_DIV, -32'sd5, 32'd0, 1'b0, cyc, stl);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFFB);

    run(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, stl);
    check("divmin_busy_cycles", cyc, 33);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'h0);

    // Flush during iteration 10 of a divide.
    op_div = 1'b1; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    op_div = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 32'h0);
    check("flush_lo", lo, 32'h8000_0000);
    repeat (40) @(negedge clk);
    check("flush_lo_later", lo, 32'h8000_0000);

    // Flush wins over a start in the same cycle.
    op_divu = 1'b1; flush = 1'b1; op_a = 32'd9; op_b = 32'd2;
    @(negedge clk);
    op_divu = 1'b0; flush = 1'b0;
    check("flush_vs_start_busy", busy, 0);

    // MTHI held by pipe_hold, then released.
    op_mthi = 1'b1; op_a = 32'h1234; pipe_hold = 1'b1;
    @(negedge clk);
    check("mthi_held_hi", hi, 32'h0);
    check("mthi_held_stall", exu_stall, 0);
    pipe_hold = 1'b0;
    @(negedge clk);
    op_mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'h8000_0000);

    // Asynchronous reset in the middle of a multiply.
    op_mult = 1'b1; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    op_mult = 1'b0; op_mflo = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_mult_stall", exu_stall, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_stall", exu_stall, 0);
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    op_mflo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
